mac_column_packer: RTL and testbench
====================================

# mac_column_packer

Serial-to-parallel packer that feeds the column adder tree. It accepts signed MAC products one per cycle over a valid/ready stream and assembles COLUMN_WIDTH of them into the packed vector that the tree reduces. It presents each completed vector on a registered valid/ready output port. An early-terminated (short) vector is zero-padded so the downstream sum stays correct.

## Interface
- COLUMN_WIDTH, 9, products per packed vector (lanes)
- DATA_WIDTH, 16, operand width of the upstream MAC
- MAC_WIDTH, DATA_WIDTH*2, width of one signed product / lane
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset; one clock, reset asynchronous and active-low
- in_valid  input  1  upstream product valid
- in_ready  output  1  packer can accept in_data this cycle
- in_data  input  MAC_WIDTH  signed MAC product
- in_last  input  1  qualifies in_data as final product of a short vector
- out_valid  output  1  out_data holds a complete vector
- out_ready  input  1  adder-tree stage accepts out_data
- out_data  output  COLUMN_WIDTH*MAC_WIDTH  packed vector; lane k at bits [k*MAC_WIDTH +: MAC_WIDTH]

## Operation
- States: FILL (collecting lanes), FULL (holding vector for downstream).
- Input handshake: word accepted when in_valid && in_ready.
- in_ready = reset && (state==FILL || (state==FULL && out_ready)); combinational pass-through of out_ready in FULL only.
- Output handshake: vector transferred when out_valid && out_ready. out_valid = (state==FULL), registered.
- lane_cnt, $clog2(COLUMN_WIDTH) bits, indexes the next lane to write; 0 after reset and after every output transfer.
- FILL: an accepted word is written to lane lane_cnt, and lane_cnt increments.
  - Go to FULL when the accepted word lands in lane COLUMN_WIDTH-1, or when in_last=1. The lane count does not wrap past COLUMN_WIDTH-1.
- Unwritten lanes read zero. The buffer is cleared to all-zero on reset and on every output transfer.
- FULL with out_ready=0: hold out_data and out_valid stable; in_ready=0.
- FULL with out_ready=1: the vector transfers and the buffer clears.
  - A word accepted in the same cycle becomes lane 0 of the next vector; lane_cnt=1, state FILL.
  - If that word has in_last=1, state stays FULL, with a vector containing only lane 0.
  - With no word accepted: lane_cnt=0, state FILL.
- in_last on the COLUMN_WIDTH-th word: identical to a normal full vector, with no extra cycle.
- in_last on the first word of a vector: the vector is that word plus COLUMN_WIDTH-1 zero lanes.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.
- Lane contents are stored bit-exact; no sign extension or arithmetic is performed.

## Timing
- Reset values: out_valid=0, out_data=0, in_ready=0 while reset is low. in_ready=1 from the first cycle after deassertion. state=FILL, lane_cnt=0.
- Latency: out_valid rises the cycle after the final lane is accepted.
- Throughput: one word per cycle sustained with out_ready held high. A full vector is produced every COLUMN_WIDTH cycles with no bubble.
- Reset asserted mid-fill or in FULL: the partial or held vector is discarded immediately (asynchronously), and out_valid drops without a handshake.
- out_data changes only on an output transfer, or on a lane write while in FILL.

## Structure
- Shared package npu_pkg holds:
  - COLUMN_WIDTH, DATA_WIDTH and MAC_WIDTH defaults, shared with the MAC array and adder tree.
  - The FILL/FULL state encoding constants.
- Single module with no sub-module. The lane counter and lane decode are inline.
- Instantiated directly ahead of the adder tree. out_data connects unchanged to the tree's packed input.

## Test plan
- Reset then 9 words 1..9, out_ready=1 -> out_valid high the cycle after word 9; lane k = k+1; next cycle in_ready=1 and lane_cnt=0.
- Words -1 (0xFFFFFFFF), 2, 3 with in_last on 3 -> lanes 0..2 = 0xFFFFFFFF, 2, 3; lanes 3..8 = 0; downstream sum = 4.
- 18 consecutive words, out_ready=1 -> two vectors, the second's lane 0 accepted in the cycle the first transfers; no idle cycles.
- Full vector with out_ready=0 for 5 cycles -> out_data stable, in_ready=0, upstream stalls; the first word after out_ready=1 goes to lane 0.
- Single word 0x7FFFFFFF with in_last while FULL is draining -> next vector = lane 0 0x7FFFFFFF, rest zero, out_valid the following cycle.
- Reset pulsed after 4 words, then 9 new words 10..18 -> the output vector contains only 10..18; no stale lanes.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU datapath sizes and packer state encoding.
// No logic; constants and types only.
// Shared by the MAC array, column packer and adder tree.
package npu_pkg;

  // Default geometry shared across the MAC array, packer and adder tree
  localparam int NPU_COLUMN_WIDTH = 9;
  localparam int NPU_DATA_WIDTH   = 16;
  localparam int NPU_MAC_WIDTH    = NPU_DATA_WIDTH * 2;

  // Column packer states: collecting lanes, or holding a finished vector
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

endpackage

// File: rtl/mac_column_packer.sv
// Serial-to-parallel packer: COLUMN_WIDTH signed MAC products -> one packed vector.
// Latency: out_valid rises the cycle after the final (or in_last) lane is accepted.
// Backpressure: while a vector is held, in_ready follows out_ready combinationally.
module mac_column_packer
  import npu_pkg::*;
#(
  parameter int COLUMN_WIDTH = NPU_COLUMN_WIDTH,
  parameter int DATA_WIDTH   = NPU_DATA_WIDTH,
  parameter int MAC_WIDTH    = DATA_WIDTH * 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [MAC_WIDTH-1:0]              in_data,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [COLUMN_WIDTH*MAC_WIDTH-1:0] out_data
);

  localparam int                CNT_W     = (COLUMN_WIDTH > 1) ? $clog2(COLUMN_WIDTH) : 1;
  localparam int                VEC_W     = COLUMN_WIDTH * MAC_WIDTH;
  localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(COLUMN_WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_lane_cnt;
  logic [CNT_W-1:0]   w_lane_cnt_nxt;
  logic [VEC_W-1:0]   r_buf;
  logic [VEC_W-1:0]   w_buf_nxt;
  logic               w_in_acc;
  logic               w_out_xfer;

  // In FULL the slot frees exactly when the held vector leaves, so a new
  // word can be taken in the same cycle as the transfer (no bubble).
  assign in_ready   = reset && ((r_state == ST_FILL) || ((r_state == ST_FULL) && out_ready));
  assign out_valid  = (r_state == ST_FULL);
  assign out_data   = r_buf;

  assign w_in_acc   = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  // Next-state, lane counter and lane-write decode
  always_comb begin
    w_state_nxt    = r_state;
    w_lane_cnt_nxt = r_lane_cnt;
    w_buf_nxt      = r_buf;

    if (r_state == ST_FILL) begin
      if (w_in_acc) begin
        for (int k = 0; k < COLUMN_WIDTH; k++) begin
          if (r_lane_cnt == CNT_W'(k)) begin
            w_buf_nxt[k*MAC_WIDTH +: MAC_WIDTH] = in_data;
          end
        end
        if (in_last || (r_lane_cnt == LAST_LANE)) begin
          w_state_nxt = ST_FULL;
        end
        // Saturate on the last lane; the counter is reloaded on transfer.
        if (r_lane_cnt != LAST_LANE) begin
          w_lane_cnt_nxt = r_lane_cnt + CNT_W'(1);
        end
      end
    end else begin
      if (w_out_xfer) begin
        // Clearing on transfer makes any unwritten lane of the next vector
        // read zero, so short vectors sum correctly in the tree.
        w_buf_nxt      = '0;
        w_lane_cnt_nxt = '0;
        w_state_nxt    = ST_FILL;
        if (w_in_acc) begin
          w_buf_nxt[MAC_WIDTH-1:0] = in_data;
          w_lane_cnt_nxt           = CNT_W'(1);
          if (in_last || (LAST_LANE == '0)) begin
            w_state_nxt = ST_FULL;
          end
        end
      end
    end
  end

  // State, counter and lane buffer registers; reset discards any partial vector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_FILL;
      r_lane_cnt <= '0;
      r_buf      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lane_cnt <= w_lane_cnt_nxt;
      r_buf      <= w_buf_nxt;
    end
  end

endmodule

// File: tb/tb_mac_column_packer.sv
// Directed bench for mac_column_packer with hand-computed vectors.
// Drives inputs 1 time unit after the rising edge and samples there too.
// Every comparison goes through check().
module tb_mac_column_packer;

  localparam int CW = 9;
  localparam int MW = 32;
  localparam int VW = CW * MW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [VW-1:0] exp_vec;
  logic [VW-1:0] held;
  int            w;
  int            stalls;
  int            sum;
  logic          stable;
  logic          ready_seen;

  always #5 clk = ~clk;

  mac_column_packer #(
    .COLUMN_WIDTH (CW),
    .DATA_WIDTH   (16),
    .MAC_WIDTH    (MW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted; returns the cycles stalled.
  task automatic send(input logic [MW-1:0] d, input logic l, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #1;
    while (!in_ready && waits < 50) begin
      step();
      #1;
      waits++;
    end
    if (!in_ready) check("send_timeout", VW'(in_ready), VW'(1));
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid", VW'(out_valid), VW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", VW'(in_ready), VW'(0));
    reset = 1'b1;
    #1;
    check("post_rst_in_ready", VW'(in_ready), VW'(1));
    check("post_rst_lane_cnt", VW'(dut.r_lane_cnt), VW'(0));
    step();

    // Full vector 1..9
    for (int i = 0; i < 8; i++) send(MW'(i + 1), 1'b0, w);
    check("t1_not_yet_valid", VW'(out_valid), VW'(0));
    send(MW'(9), 1'b0, w);
    idle();
    check("t1_valid", VW'(out_valid), VW'(1));
    exp_vec = '0;
    for (int k = 0; k < CW; k++) exp_vec[k*MW +: MW] = MW'(k + 1);
    check("t1_data", out_data, exp_vec);
    step();
    check("t1_drain_valid", VW'(out_valid), VW'(0));
    check("t1_lane_cnt", VW'(dut.r_lane_cnt), VW'(0));
    check("t1_in_ready", VW'(in_ready), VW'(1));
    check("t1_cleared", out_data, '0);

    // Short vector -1, 2, 3 with in_last
    send(32'hFFFF_FFFF, 1'b0, w);
    send(32'd2, 1'b0, w);
    send(32'd3, 1'b1, w);
    idle();
    check("t2_valid", VW'(out_valid), VW'(1));
    exp_vec = '0;
    exp_vec[0*MW +: MW] = 32'hFFFF_FFFF;
    exp_vec[1*MW +: MW] = 32'd2;
    exp_vec[2*MW +: MW] = 32'd3;
    check("t2_data", out_data, exp_vec);
    sum = 0;
    for (int k = 0; k < CW; k++) sum += $signed(out_data[k*MW +: MW]);
    check("t2_sum", VW'(sum), VW'(4));
    step();
    check("t2_drain_valid", VW'(out_valid), VW'(0));

    // 18 back-to-back words, two vectors without bubbles
    stalls = 0;
    for (int i = 0; i < 18; i++) begin
      send(MW'(100 + i), 1'b0, w);
      stalls += w;
      if (i == 8) begin
        check("t3_v1_valid", VW'(out_valid), VW'(1));
        exp_vec = '0;
        for (int k = 0; k < CW; k++) exp_vec[k*MW +: MW] = MW'(100 + k);
        check("t3_v1_data", out_data, exp_vec);
      end
      if (i == 9) begin
        check("t3_v2_filling", VW'(out_valid), VW'(0));
        exp_vec = '0;
        exp_vec[MW-1:0] = MW'(109);
        check("t3_v2_lane0", out_data, exp_vec);
      end
    end
    idle();
    check("t3_v2_valid", VW'(out_valid), VW'(1));
    exp_vec = '0;
    for (int k = 0; k < CW; k++) exp_vec[k*MW +: MW] = MW'(109 + k);
    check("t3_v2_data", out_data, exp_vec);
    check("t3_stalls", VW'(stalls), VW'(0));
    step();

    // Downstream stall for 5 cycles while upstream has a word pending
    out_ready = 1'b0;
    for (int i = 0; i < CW; i++) send(MW'(200 + i), 1'b0, w);
    in_valid   = 1'b1;
    in_data    = 32'd300;
    in_last    = 1'b0;
    held       = out_data;
    stable     = 1'b1;
    ready_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (out_data !== held || !out_valid) stable = 1'b0;
      if (in_ready) ready_seen = 1'b1;
    end
    check("t4_stable", VW'(stable), VW'(1));
    check("t4_in_ready_low", VW'(ready_seen), VW'(0));
    exp_vec = '0;
    for (int k = 0; k < CW; k++) exp_vec[k*MW +: MW] = MW'(200 + k);
    check("t4_held_data", out_data, exp_vec);
    out_ready = 1'b1;
    send(32'd300, 1'b0, w);
    check("t4_resume_wait", VW'(w), VW'(0));
    check("t4_resume_filling", VW'(out_valid), VW'(0));
    exp_vec = '0;
    exp_vec[MW-1:0] = 32'd300;
    check("t4_resume_lane0", out_data, exp_vec);
    send(32'd301, 1'b1, w);
    exp_vec[1*MW +: MW] = 32'd301;
    check("t4_short_valid", VW'(out_valid), VW'(1));
    check("t4_short_data", out_data, exp_vec);

    // Single last word accepted while the previous vector drains
    send(32'h7FFF_FFFF, 1'b1, w);
    idle();
    check("t5_valid", VW'(out_valid), VW'(1));
    exp_vec = '0;
    exp_vec[MW-1:0] = 32'h7FFF_FFFF;
    check("t5_data", out_data, exp_vec);
    step();
    check("t5_drain_valid", VW'(out_valid), VW'(0));

    // Reset while FULL drops out_valid without a handshake
    out_ready = 1'b0;
    send(32'd77, 1'b1, w);
    idle();
    check("t6_full_valid", VW'(out_valid), VW'(1));
    #2;
    reset = 1'b0;
    #1;
    check("t6_full_rst_valid", VW'(out_valid), VW'(0));
    check("t6_full_rst_data", out_data, '0);
    reset = 1'b1;
    out_ready = 1'b1;
    step();

    // Reset mid-fill discards the partial vector
    for (int i = 0; i < 4; i++) send(MW'(50 + i), 1'b0, w);
    idle();
    exp_vec = '0;
    for (int k = 0; k < 4; k++) exp_vec[k*MW +: MW] = MW'(50 + k);
    check("t7_partial", out_data, exp_vec);
    #2;
    reset = 1'b0;
    #1;
    check("t7_rst_data", out_data, '0);
    check("t7_rst_in_ready", VW'(in_ready), VW'(0));
    step();
    step();
    reset = 1'b1;
    step();
    for (int i = 0; i < CW; i++) send(MW'(10 + i), 1'b0, w);
    idle();
    check("t7_valid", VW'(out_valid), VW'(1));
    exp_vec = '0;
    for (int k = 0; k < CW; k++) exp_vec[k*MW +: MW] = MW'(10 + k);
    check("t7_data", out_data, exp_vec);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
